// File: rtl/task_clk_sequencer.sv
// task_clk_sequencer: host-driven run/halt/step control of the gated task clock, with break halts and an enabled-cycle count
module task_clk_sequencer #(
  parameter int CNT_W  = 64,
  parameter int STEP_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_resetn,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              cmd_ready,
  output logic              cmd_err,
  input  logic              break_hit,
  input  logic              difftest_break,
  input  logic              encore_en,
  output logic              clk_ce,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_cnt
);
  typedef enum logic [1:0] {HALTED, RUNNING, STEPPING} state_t;
  localparam logic [1:0] OP_HALT = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_CLEAR = 2'd3;
  localparam logic [1:0] C_HOST = 2'd0, C_BP = 2'd1, C_DF = 2'd2, C_STEP = 2'd3;
  state_t            state_q, state_d;
  logic              rdy_q, ce_q, err_q, err_d, bpm_q, bpm_d, dfm_q, dfm_d;
  logic [1:0]        cause_q, cause_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd, active, bp_ev, df_ev, host_halt, step_done;
  assign cmd       = cmd_valid & rdy_q;
  assign active    = state_q != HALTED;
  assign bp_ev     = active & break_hit & ~bpm_q;
  assign df_ev     = active & difftest_break & encore_en & ~dfm_q;
  assign host_halt = cmd & (cmd_op == OP_HALT);
  assign step_done = (state_q == STEPPING) & (step_q == STEP_W'(1));
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    step_d  = step_q;
    err_d   = 1'b0;
    cnt_d   = ce_q ? cnt_q + CNT_W'(1) : cnt_q;
    bpm_d   = break_hit & (bpm_q | bp_ev);
    dfm_d   = difftest_break & (dfm_q | df_ev);
    if (active) begin
      err_d  = cmd & (cmd_op != OP_HALT);
      step_d = (state_q == STEPPING) ? step_q - STEP_W'(1) : step_q;
      if (df_ev | bp_ev | host_halt | step_done) begin
        state_d = HALTED;
        cause_d = df_ev ? C_DF : bp_ev ? C_BP : host_halt ? C_HOST : C_STEP;
      end
    end else if (cmd) begin
      case (cmd_op)
        OP_RUN: begin
          state_d = RUNNING;
          cause_d = C_HOST;
        end
        OP_STEP: begin
          state_d = (cmd_arg != '0) ? STEPPING : HALTED;
          step_d  = cmd_arg;
          cause_d = (cmd_arg != '0) ? cause_q : C_STEP;
        end
        OP_CLEAR: begin
          cnt_d   = '0;
          cause_d = C_HOST;
        end
        default: ;
      endcase
    end
  end
  // rdy_q delays command acceptance until the edge after reset release
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      rdy_q   <= 1'b0;
      state_q <= HALTED;
      ce_q    <= 1'b0;
      err_q   <= 1'b0;
      bpm_q   <= 1'b0;
      dfm_q   <= 1'b0;
      cause_q <= C_HOST;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      rdy_q   <= 1'b1;
      state_q <= state_d;
      ce_q    <= state_d != HALTED;
      err_q   <= err_d;
      bpm_q   <= bpm_d;
      dfm_q   <= dfm_d;
      cause_q <= cause_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end
  assign cmd_ready  = rdy_q;
  assign cmd_err    = err_q;
  assign clk_ce     = ce_q;
  assign halted     = state_q == HALTED;
  assign halt_cause = cause_q;
  assign cycle_cnt  = cnt_q;
endmodule

// File: tb/tb_task_clk_sequencer.sv
// tb_task_clk_sequencer: scoreboard bench against a cycle-level behavioural model of the sequencer
module tb_task_clk_sequencer;
  localparam int CNT_W = 10, STEP_W = 32;
  typedef enum {M_HALT, M_RUN, M_STEP} mode_t;
  typedef struct {
    logic             ready, ce, halted, err;
    logic [1:0]       cause;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  logic              sys_clk = 1'b0, sys_resetn = 1'b0, cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'd0;
  logic [STEP_W-1:0] cmd_arg = '0;
  logic              break_hit = 1'b0, difftest_break = 1'b0, encore_en = 1'b0;
  logic              cmd_ready, cmd_err, clk_ce, halted;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  cycle_cnt;
  exp_t              sb[$];
  int                vectors = 0, miscompares = 0;
  mode_t             m_mode;
  int unsigned       m_left;
  int                m_cause;
  longint            m_cnt;
  bit                m_err, m_bpm, m_dfm, m_ready;
  task_clk_sequencer #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .cmd_ready(cmd_ready), .cmd_err(cmd_err), .break_hit(break_hit),
    .difftest_break(difftest_break), .encore_en(encore_en), .clk_ce(clk_ce), .halted(halted),
    .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  function automatic exp_t snap();
    exp_t e;
    e.ready  = m_ready;
    e.ce     = m_mode != M_HALT;
    e.halted = m_mode == M_HALT;
    e.err    = m_err;
    e.cause  = 2'(m_cause);
    e.cnt    = CNT_W'(m_cnt);
    return e;
  endfunction
  task automatic model_reset();
    m_mode = M_HALT; m_left = 0; m_cause = 0; m_cnt = 0;
    m_err = 0; m_bpm = 0; m_dfm = 0; m_ready = 0;
  endtask
  task automatic model_edge();
    bit active, take, bp, df, hh, done;
    active = m_mode != M_HALT;
    take   = cmd_valid && m_ready;
    bp     = active && break_hit && !m_bpm;
    df     = active && difftest_break && encore_en && !m_dfm;
    if (active) m_cnt = (m_cnt + 1) % (64'd1 << CNT_W);
    m_err = 0;
    if (active) begin
      hh    = take && cmd_op == 2'd0;
      m_err = take && cmd_op != 2'd0;
      done  = 0;
      if (m_mode == M_STEP) begin
        m_left--;
        done = m_left == 0;
      end
      if (df || bp || hh || done) begin
        m_mode  = M_HALT;
        m_cause = df ? 2 : bp ? 1 : hh ? 0 : 3;
      end
    end else if (take) begin
      if (cmd_op == 2'd1) begin m_mode = M_RUN; m_cause = 0; end
      if (cmd_op == 2'd2 && cmd_arg == 0) m_cause = 3;
      if (cmd_op == 2'd2 && cmd_arg != 0) begin m_mode = M_STEP; m_left = cmd_arg; end
      if (cmd_op == 2'd3) begin m_cnt = 0; m_cause = 0; end
    end
    if (bp) m_bpm = 1;
    if (df) m_dfm = 1;
    if (!break_hit) m_bpm = 0;
    if (!difftest_break) m_dfm = 0;
    m_ready = 1;
  endtask
  task automatic cyc(input bit v = 0, input logic [1:0] op = 2'd0, input int unsigned arg = 0);
    cmd_valid = v; cmd_op = op; cmd_arg = arg;
    model_edge();
    @(posedge sys_clk);
    sb.push_back(snap());
    #1;
    cmd_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc();
  endtask
  initial forever begin
    @(negedge sys_clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("cmd_ready", 64'(cmd_ready), 64'(e.ready));
      chk("clk_ce", 64'(clk_ce), 64'(e.ce));
      chk("halted", 64'(halted), 64'(e.halted));
      chk("cmd_err", 64'(cmd_err), 64'(e.err));
      chk("halt_cause", 64'(halt_cause), 64'(e.cause));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(e.cnt));
    end
  end
  initial begin
    model_reset();
    sb.push_back(snap());
    @(posedge sys_clk); #1;
    sys_resetn = 1'b1;
    idle(2);
    cyc(1, 2'd1); idle(99); cyc(1, 2'd0); idle(3);
    cyc(1, 2'd2, 5); idle(8); cyc(1, 2'd2, 0); idle(3);
    cyc(1, 2'd1); idle(5); break_hit = 1; idle(4); cyc(1, 2'd1); idle(10);
    break_hit = 0; idle(3); break_hit = 1; idle(3); break_hit = 0; idle(2);
    cyc(1, 2'd1); difftest_break = 1; encore_en = 0; idle(5); encore_en = 1; idle(3);
    difftest_break = 0; idle(2); cyc(1, 2'd1); idle(3);
    difftest_break = 1; break_hit = 1; idle(3); difftest_break = 0; break_hit = 0; idle(2);
    cyc(1, 2'd2, 3); cyc(); break_hit = 1; cyc(); idle(3); break_hit = 0; idle(2);
    cyc(1, 2'd1); idle(3); cyc(1, 2'd1); idle(2); cyc(1, 2'd2, 4); cyc(1, 2'd3); cyc(1, 2'd0); idle(2);
    cyc(1, 2'd1); idle(2); break_hit = 1; cyc(1, 2'd0); break_hit = 0; idle(2);
    cyc(1, 2'd1); idle(1100); cyc(1, 2'd0); cyc(1, 2'd3); idle(2);
    cyc(1, 2'd2, 50); idle(5);
    @(negedge sys_clk); #1;
    sys_resetn = 1'b0; #1;
    chk("async_clk_ce", 64'(clk_ce), 64'd0);
    chk("async_halted", 64'(halted), 64'd1);
    model_reset();
    sb.push_back(snap());
    @(posedge sys_clk); #1;
    sys_resetn = 1'b1;
    idle(1); cyc(1, 2'd2, 2); idle(4);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) break_hit = ~break_hit;
      if ($urandom_range(0, 19) == 0) difftest_break = ~difftest_break;
      if ($urandom_range(0, 49) == 0) encore_en = ~encore_en;
      if ($urandom_range(0, 7) == 0) cyc(1, 2'($urandom_range(0, 3)), $urandom_range(0, 8));
      else cyc();
    end
    break_hit = 0; difftest_break = 0;
    idle(2);
    @(negedge sys_clk); #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
